// File: rtl/gate_array_pkg.sv
// Shared opcode definitions for the pipelined bitwise gate array.
// Opcode values are part of the external interface and must not be renumbered.
package gate_array_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOTA = 3'd6,
        OP_PASS = 3'd7
    } gate_op_t;

    localparam int GATE_OP_W = 3;

endpackage

// File: rtl/gate_array_core.sv
// Combinational bitwise operator: (op, a, b) -> (y, zero, parity).
// Flags are derived from the full-width result, so inverting ops flip every bit first.
module gate_array_core
    import gate_array_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  gate_op_t         i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y,
    output logic             o_zero,
    output logic             o_par
);

    always_comb begin
        o_y = '0;
        case (i_op)
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            OP_NAND: o_y = ~(i_a & i_b);
            OP_NOR:  o_y = ~(i_a | i_b);
            OP_XNOR: o_y = ~(i_a ^ i_b);
            OP_NOTA: o_y = ~i_a;
            OP_PASS: o_y = i_a;
            default: o_y = '0;
        endcase
    end

    assign o_zero = (o_y == '0);
    assign o_par  = ^o_y;

endmodule

// File: rtl/gate_array_pipe.sv
// Two-stage valid/ready pipeline around gate_array_core with result flags and
// a saturating count of results taken by the consumer.
module gate_array_pipe
    import gate_array_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_par,
    output logic [CNT_W-1:0] done_cnt,
    input  logic             clr_cnt
);

    logic             r_s1_valid;
    gate_op_t         r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_y;
    logic             r_out_zero;
    logic             r_out_par;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s1_load;
    logic             w_s2_load;
    logic             w_out_fire;
    logic [WIDTH-1:0] w_y;
    logic             w_zero;
    logic             w_par;

    // S1 may refill in the same cycle it drains into S2, so ready looks through both stages.
    assign in_ready   = !r_s1_valid || !r_out_valid || out_ready;
    assign w_s1_load  = in_valid && in_ready;
    assign w_s2_load  = r_s1_valid && (!r_out_valid || out_ready);
    assign w_out_fire = r_out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= OP_AND;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= 1'b1;
            r_s1_op    <= gate_op_t'(in_op);
            r_s1_a     <= in_a;
            r_s1_b     <= in_b;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    gate_array_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_op   (r_s1_op),
        .i_a    (r_s1_a),
        .i_b    (r_s1_b),
        .o_y    (w_y),
        .o_zero (w_zero),
        .o_par  (w_par)
    );

    // Output registers only move on a load, which keeps the beat stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
            r_out_zero  <= 1'b0;
            r_out_par   <= 1'b0;
        end else if (w_s2_load) begin
            r_out_valid <= 1'b1;
            r_out_y     <= w_y;
            r_out_zero  <= w_zero;
            r_out_par   <= w_par;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr_cnt) begin
            r_cnt <= '0;
        end else if (w_out_fire && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out_valid = r_out_valid;
    assign out_y     = r_out_y;
    assign out_zero  = r_out_zero;
    assign out_par   = r_out_par;
    assign done_cnt  = r_cnt;

endmodule

// File: doc/gate_array_pipe.md
# gate_array_pipe

Parametrised, pipelined successor to the single-bit two-input gate: applies one of eight bitwise logic operations to two WIDTH-bit operands, registered through two pipeline stages with valid/ready flow control on both sides. Sits between a request source and a result consumer in the logic-datapath area; also reports zero and parity flags and keeps a saturating count of completed results.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- CNT_W, 16, width of completed-result counter (≥1)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts beat this cycle
- in_op  input  3  operation code (gate_op_t)
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result this cycle
- out_y  output  WIDTH  result
- out_zero  output  1  out_y == 0
- out_par  output  1  XOR-reduction of out_y
- done_cnt  output  CNT_W  results accepted by consumer, saturating
- clr_cnt  input  1  synchronous clear of done_cnt

## Operation
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A (in_b ignored), 7 PASS A.
- Stage 1 (S1): captures in_op/in_a/in_b on in_valid && in_ready; holds s1_valid.
- Stage 2 (S2): computes result from S1 contents, registers out_y, out_zero, out_par; holds out_valid.
- S2 loads when s1_valid && (!out_valid || out_ready); S1 drains in the same cycle.
- in_ready = !s1_valid || !out_valid || out_ready (combinational; pipeline fully utilised, one beat per cycle at full throughput).
- Output beat held stable (out_y, flags, out_valid) while out_valid && !out_ready.
- done_cnt increments on out_valid && out_ready; saturates at 2^CNT_W−1; clr_cnt has priority over increment in the same cycle.
- Reset: s1_valid=0, out_valid=0, out_y=0, out_zero=0, out_par=0, done_cnt=0; in_ready=1 after reset deassertion. Reset mid-operation discards all in-flight beats.
- Flags computed on the full WIDTH result; NAND/NOR/XNOR/NOT invert all WIDTH bits.

## Timing
- Latency: beat accepted at edge N → out_valid asserted after edge N+1 (two registers, visible in cycle N+1 after edge).
- Throughput: 1 beat/clock with out_ready held high.
- Backpressure: out_ready low with both stages full → in_ready low same cycle; no beat dropped or duplicated.
- Simultaneous S2 drain and S1 refill in one cycle supported.
- in_* sampled only on in_valid && in_ready; values otherwise don't-care.
- Reset asserts asynchronously, deasserts synchronously to clk (external synchroniser).

## Structure
- Package gate_array_pkg: gate_op_t enum (the eight opcodes, 3 bits), OP_* constants.
- Sub-module gate_array_core: purely combinational, WIDTH-parametrised, (op, a, b) → (y, zero, par); instantiated once between S1 and S2.
- Top gate_array_pipe holds both stage registers, handshake logic and counter.

## Test plan
- Reset: rst_n low mid-stream → out_valid=0, out_y=0, done_cnt=0, in_ready=1 after release; no stale beat emerges.
- All ops, WIDTH=8, a=8'hC5, b=8'h3A, out_ready=1: AND 00 (zero=1), OR FF (par=0), XOR FF, NAND FF, NOR 00, XNOR 00, NOT A 3A (par=0), PASS C5 (par=0); each result 2 cycles after acceptance.
- Streaming: 16 back-to-back beats, out_ready=1 → 16 results in order on 16 consecutive cycles, done_cnt=16.
- Backpressure: fill with 3 beats, hold out_ready=0 for 5 cycles → in_ready=0 after 2 accepted, out_y stable; release → remaining beats delivered in order, none lost.
- Counter: CNT_W=2, 5 accepted results → done_cnt=3 (saturated); clr_cnt asserted on a cycle with accepted result → done_cnt=0.
- Random: random in_valid/out_ready/op/operands over 10k cycles vs scoreboard model → zero mismatches, order preserved.
